// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: requester indices, FSM
// states and round-robin helpers.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ = 3;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_DMA   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Successor of a requester index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : 2'(idx + 2'd1);
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational 3-way round-robin picker; search starts at ptr and wraps.
module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] index
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    // An out-of-range pointer behaves like pointer 0.
    cand0 = (ptr > 2'd2) ? 2'd0 : ptr;
    cand1 = rr_next(cand0);
    cand2 = rr_next(cand1);
    gnt   = '0;
    index = '0;
    if (req[cand0]) begin
      index = cand0;
    end else if (req[cand1]) begin
      index = cand1;
    end else if (req[cand2]) begin
      index = cand2;
    end
    if (req != '0) begin
      gnt = onehot3(index);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter for fetch, control-unit data and DMA
// requesters: round-robin grant, bounded lock for RMW, fixed read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              i_req,
  input  logic [2:0]              i_we,
  input  logic [2:0]              i_lock,
  input  logic [3*ADDR_WIDTH-1:0] i_addr,
  input  logic [3*DWIDTH-1:0]     i_wdata,
  output logic [2:0]              o_gnt,
  output logic [2:0]              o_ack,
  output logic [DWIDTH-1:0]       o_rdata,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_we,
  output logic                    o_mem_ce,
  output logic [DWIDTH-1:0]       o_mem_wdata,
  input  logic [DWIDTH-1:0]       i_mem_rdata,
  output logic                    o_busy
);

  localparam int unsigned WAIT_W = 2;
  localparam int unsigned LOCK_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  arb_state_e        state;
  arb_state_e        state_n;
  logic [1:0]        rr_ptr;
  logic [1:0]        rr_ptr_n;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_n;
  logic [1:0]        owner;
  logic [1:0]        owner_n;
  logic              cur_we;
  logic              cur_we_n;

  logic [2:0]            gnt_n;
  logic [2:0]            ack_n;
  logic [DWIDTH-1:0]     rdata_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic                  mem_we_n;
  logic                  mem_ce_n;
  logic [DWIDTH-1:0]     mem_wdata_n;
  logic                  busy_n;

  logic [2:0] pick_gnt;
  logic [1:0] pick_index;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DWIDTH-1:0]     wdata_arr [NUM_REQ];
  logic [1:0]            cap_idx;

  mem_rr_pick u_pick (
    .req   (i_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .index (pick_index)
  );

  // Unpack the per-requester address and write-data buses.
  always_comb begin
    for (int n = 0; n < int'(NUM_REQ); n++) begin
      addr_arr[n]  = i_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[n] = i_wdata[n*DWIDTH +: DWIDTH];
    end
  end

  // New winner from IDLE, otherwise the current owner continuing a lock.
  assign cap_idx = (state == IDLE) ? pick_index : owner;

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    lock_cnt_n  = lock_cnt;
    wait_cnt_n  = wait_cnt;
    owner_n     = owner;
    cur_we_n    = cur_we;
    gnt_n       = o_gnt;
    ack_n       = '0;
    rdata_n     = o_rdata;
    mem_addr_n  = o_mem_addr;
    mem_we_n    = 1'b0;
    mem_ce_n    = 1'b0;
    mem_wdata_n = o_mem_wdata;

    case (state)
      IDLE: begin
        if (i_req != '0) begin
          owner_n     = pick_index;
          gnt_n       = pick_gnt;
          mem_addr_n  = addr_arr[cap_idx];
          mem_wdata_n = wdata_arr[cap_idx];
          mem_we_n    = i_we[cap_idx];
          cur_we_n    = i_we[cap_idx];
          mem_ce_n    = 1'b1;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        wait_cnt_n = '0;
        if (cur_we) begin
          ack_n   = o_gnt;
          state_n = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
          rdata_n = i_mem_rdata;
          ack_n   = o_gnt;
          state_n = RESP;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_W'(1);
        end
      end
      RESP: begin
        // Locked continuation keeps the grant but is capped at MAX_LOCK accesses.
        if (i_lock[owner] && i_req[owner] && (lock_cnt < LOCK_W'(MAX_LOCK - 1))) begin
          mem_addr_n  = addr_arr[cap_idx];
          mem_wdata_n = wdata_arr[cap_idx];
          mem_we_n    = i_we[cap_idx];
          cur_we_n    = i_we[cap_idx];
          mem_ce_n    = 1'b1;
          lock_cnt_n  = lock_cnt + LOCK_W'(1);
          state_n     = ACCESS;
        end else begin
          gnt_n      = '0;
          rr_ptr_n   = rr_next(owner);
          lock_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_cnt    <= '0;
      wait_cnt    <= '0;
      owner       <= '0;
      cur_we      <= 1'b0;
      o_gnt       <= '0;
      o_ack       <= '0;
      o_rdata     <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_ce    <= 1'b0;
      o_mem_wdata <= '0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      lock_cnt    <= lock_cnt_n;
      wait_cnt    <= wait_cnt_n;
      owner       <= owner_n;
      cur_we      <= cur_we_n;
      o_gnt       <= gnt_n;
      o_ack       <= ack_n;
      o_rdata     <= rdata_n;
      o_mem_addr  <= mem_addr_n;
      o_mem_we    <= mem_we_n;
      o_mem_ce    <= mem_ce_n;
      o_mem_wdata <= mem_wdata_n;
      o_busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (RD_LAT=1 and RD_LAT=3 instances) and
// the standalone round-robin picker.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset_n;
  logic [2:0]    i_req;
  logic [2:0]    i_we;
  logic [2:0]    i_lock;
  logic [3*AW-1:0] i_addr;
  logic [3*DW-1:0] i_wdata;

  logic [2:0]    o_gnt, o_ack;
  logic [DW-1:0] o_rdata, o_mem_wdata, rd1;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we, o_mem_ce, o_busy;

  logic [2:0]    gnt3, ack3;
  logic [DW-1:0] rdata3, mwdata3, rd3;
  logic [AW-1:0] maddr3;
  logic          mwe3, mce3, busy3;

  logic [2:0]    pk_req, pk_gnt;
  logic [1:0]    pk_ptr, pk_idx;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem [4096];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DWIDTH(DW), .RD_LAT(1), .MAX_LOCK(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_we(i_we), .i_lock(i_lock),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_ack(o_ack),
    .o_rdata(o_rdata), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_ce(o_mem_ce), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(rd1),
    .o_busy(o_busy)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DWIDTH(DW), .RD_LAT(3), .MAX_LOCK(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_we(i_we), .i_lock(i_lock),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(gnt3), .o_ack(ack3),
    .o_rdata(rdata3), .o_mem_addr(maddr3), .o_mem_we(mwe3),
    .o_mem_ce(mce3), .o_mem_wdata(mwdata3), .i_mem_rdata(rd3),
    .o_busy(busy3)
  );

  mem_rr_pick u_pick (.req(pk_req), .ptr(pk_ptr), .gnt(pk_gnt), .index(pk_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: written only by the RD_LAT=1 instance, read by both.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (o_mem_ce && o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_ce && !o_mem_we) rd1 <= mem[o_mem_addr];
    if (mce3 && !mwe3) rd3 <= mem[maddr3];
  end

  typedef struct packed {
    logic [2:0] req;
    logic [1:0] ptr;
    logic [2:0] gnt;
    logic [1:0] idx;
  } pick_vec_t;

  pick_vec_t pv [24];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    i_we[n]           = we;
    i_addr[n*AW +: AW] = a;
    i_wdata[n*DW +: DW] = d;
    i_lock[n]         = lk;
    i_req[n]          = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic do_reset;
    i_req   = '0;
    i_lock  = '0;
    i_we    = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle;
    int c = 0;
    while (o_busy && c < 20) begin
      step();
      c++;
    end
    check("idle_timeout", 32'(o_busy), 32'h0);
  endtask

  task automatic wait_ack(input logic [2:0] who, input string name);
    bit got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      step();
      if (o_ack == who) got = 1'b1;
    end
    check(name, 32'(got), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] acks [5];
    int         nacks;
    int         ndata;
    bit         seen_dma;

    i_req = '0; i_we = '0; i_lock = '0; i_addr = '0; i_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    reset_n = 1'b0;

    // Picker vectors: {req, ptr, gnt, index}
    pv = '{
      '{3'b000, 2'd0, 3'b000, 2'd0}, '{3'b000, 2'd1, 3'b000, 2'd0}, '{3'b000, 2'd2, 3'b000, 2'd0},
      '{3'b001, 2'd0, 3'b001, 2'd0}, '{3'b001, 2'd1, 3'b001, 2'd0}, '{3'b001, 2'd2, 3'b001, 2'd0},
      '{3'b010, 2'd0, 3'b010, 2'd1}, '{3'b010, 2'd1, 3'b010, 2'd1}, '{3'b010, 2'd2, 3'b010, 2'd1},
      '{3'b011, 2'd0, 3'b001, 2'd0}, '{3'b011, 2'd1, 3'b010, 2'd1}, '{3'b011, 2'd2, 3'b001, 2'd0},
      '{3'b100, 2'd0, 3'b100, 2'd2}, '{3'b100, 2'd1, 3'b100, 2'd2}, '{3'b100, 2'd2, 3'b100, 2'd2},
      '{3'b101, 2'd0, 3'b001, 2'd0}, '{3'b101, 2'd1, 3'b100, 2'd2}, '{3'b101, 2'd2, 3'b100, 2'd2},
      '{3'b110, 2'd0, 3'b010, 2'd1}, '{3'b110, 2'd1, 3'b010, 2'd1}, '{3'b110, 2'd2, 3'b100, 2'd2},
      '{3'b111, 2'd0, 3'b001, 2'd0}, '{3'b111, 2'd1, 3'b010, 2'd1}, '{3'b111, 2'd2, 3'b100, 2'd2}
    };
    for (int i = 0; i < 24; i++) begin
      pk_req = pv[i].req;
      pk_ptr = pv[i].ptr;
      #1;
      check($sformatf("pick_gnt[%0d]", i), 32'(pk_gnt), 32'(pv[i].gnt));
      check($sformatf("pick_idx[%0d]", i), 32'(pk_idx), 32'(pv[i].idx));
    end

    // Reset state
    step();
    step();
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_ack", 32'(o_ack), 32'h0);
    check("rst_ce", 32'(o_mem_ce), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_rdata", 32'(o_rdata), 32'h0);
    reset_n = 1'b1;
    preload(12'h010, 16'h1234);

    // Fetch read, RD_LAT=1
    set_req(0, 1'b0, 12'h010, 16'h0, 1'b0);
    step();
    check("rd_gnt_c1", 32'(o_gnt), 32'h1);
    check("rd_ce_c1", 32'(o_mem_ce), 32'h1);
    check("rd_we_c1", 32'(o_mem_we), 32'h0);
    check("rd_addr_c1", 32'(o_mem_addr), 32'h010);
    check("rd_busy_c1", 32'(o_busy), 32'h1);
    step();
    check("rd_ce_c2", 32'(o_mem_ce), 32'h0);
    check("rd_ack_c2", 32'(o_ack), 32'h0);
    step();
    check("rd_ack_c3", 32'(o_ack), 32'h1);
    check("rd_rdata_c3", 32'(o_rdata), 32'h1234);
    i_req = '0;
    step();
    check("rd_busy_c4", 32'(o_busy), 32'h0);
    check("rd_ack_c4", 32'(o_ack), 32'h0);
    check("rd_addr_hold", 32'(o_mem_addr), 32'h010);

    // DMA write
    set_req(2, 1'b1, 12'hABC, 16'h5A5A, 1'b0);
    step();
    check("wr_gnt_c1", 32'(o_gnt), 32'h4);
    check("wr_ce_c1", 32'(o_mem_ce), 32'h1);
    check("wr_we_c1", 32'(o_mem_we), 32'h1);
    check("wr_wdata_c1", 32'(o_mem_wdata), 32'h5A5A);
    check("wr_addr_c1", 32'(o_mem_addr), 32'hABC);
    step();
    check("wr_ack_c2", 32'(o_ack), 32'h4);
    check("wr_we_c2", 32'(o_mem_we), 32'h0);
    check("wr_rdata_kept", 32'(o_rdata), 32'h1234);
    i_req = '0;
    i_we  = '0;
    step();
    check("wr_busy_c3", 32'(o_busy), 32'h0);

    // Read back the DMA-written word via the data requester
    set_req(1, 1'b0, 12'hABC, 16'h0, 1'b0);
    wait_ack(3'b010, "rb_ack");
    check("rb_rdata", 32'(o_rdata), 32'h5A5A);
    i_req = '0;
    step();
    wait_idle();

    // Reset during WAIT drops the access
    set_req(0, 1'b0, 12'h010, 16'h0, 1'b0);
    step();
    check("rst_mid_ce", 32'(o_mem_ce), 32'h1);
    step();
    reset_n = 1'b0;
    i_req   = '0;
    step();
    check("rst_mid_gnt", 32'(o_gnt), 32'h0);
    check("rst_mid_ack", 32'(o_ack), 32'h0);
    check("rst_mid_rdata", 32'(o_rdata), 32'h0);
    check("rst_mid_addr", 32'(o_mem_addr), 32'h0);
    check("rst_mid_busy", 32'(o_busy), 32'h0);
    reset_n = 1'b1;
    set_req(1, 1'b0, 12'h010, 16'h0, 1'b0);
    set_req(2, 1'b0, 12'h010, 16'h0, 1'b0);
    step();
    check("rst_mid_noack", 32'(o_ack), 32'h0);
    check("rst_mid_regnt", 32'(o_gnt), 32'h2);
    i_req = '0;
    step();
    wait_idle();

    // RD_LAT=3 instance: ack in cycle 5
    do_reset();
    set_req(1, 1'b0, 12'h010, 16'h0, 1'b0);
    step();
    check("lat3_ce_c1", 32'(mce3), 32'h1);
    check("lat3_gnt_c1", 32'(gnt3), 32'h2);
    step();
    step();
    step();
    check("lat3_ack_c4", 32'(ack3), 32'h0);
    check("lat3_busy_c4", 32'(busy3), 32'h1);
    step();
    check("lat3_ack_c5", 32'(ack3), 32'h2);
    check("lat3_rdata_c5", 32'(rdata3), 32'h1234);
    i_req = '0;

    // Round-robin fairness under continuous requests
    do_reset();
    set_req(0, 1'b0, 12'h001, 16'h0, 1'b0);
    set_req(1, 1'b0, 12'h002, 16'h0, 1'b0);
    set_req(2, 1'b0, 12'h003, 16'h0, 1'b0);
    nacks = 0;
    for (int c = 0; c < 60 && nacks < 5; c++) begin
      step();
      if (o_ack != '0) begin
        acks[nacks] = o_ack;
        nacks++;
      end
    end
    check("fair_count", 32'(nacks), 32'h5);
    if (nacks == 5) begin
      check("fair_ack0", 32'(acks[0]), 32'h1);
      check("fair_ack1", 32'(acks[1]), 32'h2);
      check("fair_ack2", 32'(acks[2]), 32'h4);
      check("fair_ack3", 32'(acks[3]), 32'h1);
      check("fair_ack4", 32'(acks[4]), 32'h2);
    end
    i_req = '0;
    step();
    wait_idle();

    // ISZ read-modify-write under lock while fetch waits
    do_reset();
    preload(12'h020, 16'h0007);
    set_req(0, 1'b0, 12'h010, 16'h0, 1'b0);
    wait_ack(3'b001, "isz_prep_ack");
    i_req = '0;
    step();
    wait_idle();
    set_req(0, 1'b0, 12'h030, 16'h0, 1'b0);
    set_req(1, 1'b0, 12'h020, 16'h0, 1'b1);
    step();
    check("isz_gnt_c1", 32'(o_gnt), 32'h2);
    check("isz_addr_c1", 32'(o_mem_addr), 32'h020);
    step();
    step();
    check("isz_ack_rd", 32'(o_ack), 32'h2);
    check("isz_rdata", 32'(o_rdata), 32'h0007);
    i_we[1] = 1'b1;
    i_wdata[1*DW +: DW] = 16'h0008;
    step();
    check("isz_gnt_wr", 32'(o_gnt), 32'h2);
    check("isz_ce_wr", 32'(o_mem_ce), 32'h1);
    check("isz_we_wr", 32'(o_mem_we), 32'h1);
    check("isz_wdata", 32'(o_mem_wdata), 32'h0008);
    check("isz_busy_nogap", 32'(o_busy), 32'h1);
    i_lock[1] = 1'b0;
    step();
    check("isz_ack_wr", 32'(o_ack), 32'h2);
    i_req[1] = 1'b0;
    step();
    check("isz_gnt_idle", 32'(o_gnt), 32'h0);
    step();
    check("isz_fetch_gnt", 32'(o_gnt), 32'h1);
    i_req = '0;
    i_we  = '0;
    step();
    wait_idle();

    // Lock bound: data locks continuously while DMA waits
    do_reset();
    set_req(1, 1'b1, 12'h100, 16'h1111, 1'b1);
    set_req(2, 1'b1, 12'h200, 16'h2222, 1'b0);
    ndata = 0;
    seen_dma = 1'b0;
    for (int c = 0; c < 60 && !seen_dma; c++) begin
      step();
      if (o_ack == 3'b010) ndata++;
      if (o_gnt == 3'b100) seen_dma = 1'b1;
    end
    check("lock_dma_gnt", 32'(seen_dma), 32'h1);
    check("lock_count", 32'(ndata), 32'h4);
    i_req  = '0;
    i_lock = '0;
    i_we   = '0;
    step();
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
